vram_wr_sched: RTL and testbench

VRAM_WR_SCHED -- requirements
Module: vram_wr_sched

---
 rtl/chr_gen_pkg.sv | 19 +
 rtl/vram_wr_fifo.sv | 50 +++++
 rtl/vram_wr_sched.sv | 135 +++++++++++++
 tb/tb_vram_wr_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chr_gen_pkg.sv
// Shared VRAM geometry, write-scheduler state encoding and write request payload.
package chr_gen_pkg;

  localparam int unsigned C_VRAM_AW    = 10;
  localparam int unsigned C_VRAM_DW    = 8;
  localparam int unsigned C_VRAM_WORDS = 1024;
  localparam int unsigned C_REQ_W      = C_VRAM_AW + C_VRAM_DW;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [C_VRAM_AW-1:0] addr;
    logic [C_VRAM_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO for queued CPU VRAM writes; a push on full is accepted only with a same-cycle pop.
module vram_wr_fifo
  import chr_gen_pkg::*;
#(
  parameter int unsigned C_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wr_req_t                  wdata,
  output wr_req_t                  rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(C_DEPTH):0] level
);

  localparam int unsigned C_PW = $clog2(C_DEPTH);
  localparam int unsigned C_LW = C_PW + 1;

  wr_req_t         mem [C_DEPTH];
  logic [C_PW-1:0] wr_ptr;
  logic [C_PW-1:0] rd_ptr;
  logic            do_pop;
  logic            do_push;

  assign full_c  = (level == C_LW'(C_DEPTH));
  assign empty_c = (level == '0);
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);
  assign rdata_c = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + C_PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + C_PW'(1);
      level <= level + C_LW'(do_push) - C_LW'(do_pop);
    end
  end

endmodule

// File: rtl/vram_wr_sched.sv
// Schedules queued CPU writes and full-VRAM clear fills onto the single VRAM write port,
// optionally restricted to the blanking window.
module vram_wr_sched
  import chr_gen_pkg::*;
#(
  parameter int unsigned C_FIFO_DEPTH = 8,
  parameter int unsigned C_BLANK_ONLY = 1
) (
  input  logic                          CK_i,
  input  logic                          XARST_i,
  input  logic [9:0]                    CPU_WAs_i,
  input  logic [7:0]                    CPU_WDs_i,
  input  logic                          CPU_WE_i,
  input  logic                          CLR_REQ_i,
  input  logic [7:0]                    CLR_DATs_i,
  input  logic                          BLANK_i,
  input  logic                          OVF_CLR_i,
  output logic [9:0]                    VRAM_WAs_o,
  output logic [7:0]                    VRAM_WDs_o,
  output logic                          VRAM_WE_o,
  output logic                          BUSY_o,
  output logic                          OVF_o,
  output logic [$clog2(C_FIFO_DEPTH):0] FIFO_LVLs_o
);

  localparam int unsigned          C_LW        = $clog2(C_FIFO_DEPTH) + 1;
  localparam logic [C_VRAM_AW-1:0] C_LAST_ADDR = C_VRAM_AW'(C_VRAM_WORDS - 1);

  wr_state_t            state;
  logic [C_VRAM_AW-1:0] fill_addr;
  logic                 cpu_we_d;
  logic                 clr_d;
  logic                 clr_pend;

  wr_req_t   req;
  wr_req_t   head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      win;
  logic      push;
  logic      pop;
  logic      push_ok;
  logic      ovf_ev;
  logic      clr_rise;
  logic      pend_set;
  logic      go_fill;
  logic      fill_wr;
  logic      fill_done;
  logic [C_LW-1:0] lvl_nxt;
  logic      busy_nxt;

  assign req       = '{addr: CPU_WAs_i, data: CPU_WDs_i};
  assign win       = BLANK_i | (C_BLANK_ONLY == 0);
  assign push      = CPU_WE_i & ~cpu_we_d;
  assign clr_rise  = CLR_REQ_i & ~clr_d;
  assign pop       = (state == ST_IDLE) & win & ~fifo_empty;
  assign push_ok   = push & (~fifo_full | pop);
  assign ovf_ev    = push & fifo_full & ~pop;
  assign pend_set  = clr_rise & ~clr_pend & (state != ST_FILL);
  assign go_fill   = (state == ST_IDLE) & clr_pend & fifo_empty;
  assign fill_wr   = (state == ST_FILL) & win;
  assign fill_done = fill_wr & (fill_addr == C_LAST_ADDR);

  // Busy is registered, so it is derived from the post-edge occupancy and state.
  assign lvl_nxt  = FIFO_LVLs_o + C_LW'(push_ok) - C_LW'(pop);
  assign busy_nxt = (lvl_nxt != '0) | ((clr_pend | pend_set) & ~go_fill) | go_fill
                  | ((state == ST_FILL) & ~fill_done);

  vram_wr_fifo #(
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (CK_i),
    .rst_n   (XARST_i),
    .push    (push),
    .pop     (pop),
    .wdata   (req),
    .rdata_c (head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .level   (FIFO_LVLs_o)
  );

  // Edge detectors reset high so a strobe held across reset release is not a request.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state      <= ST_IDLE;
      fill_addr  <= '0;
      cpu_we_d   <= 1'b1;
      clr_d      <= 1'b1;
      clr_pend   <= 1'b0;
      VRAM_WAs_o <= '0;
      VRAM_WDs_o <= '0;
      VRAM_WE_o  <= 1'b0;
      BUSY_o     <= 1'b0;
      OVF_o      <= 1'b0;
    end else begin
      cpu_we_d  <= CPU_WE_i;
      clr_d     <= CLR_REQ_i;
      BUSY_o    <= busy_nxt;
      VRAM_WE_o <= 1'b0;
      if (ovf_ev)         OVF_o <= 1'b1;
      else if (OVF_CLR_i) OVF_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            VRAM_WAs_o <= head.addr;
            VRAM_WDs_o <= head.data;
            VRAM_WE_o  <= 1'b1;
          end
          if (go_fill) begin
            state    <= ST_FILL;
            clr_pend <= 1'b0;
          end else if (pend_set) begin
            clr_pend <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_wr) begin
            VRAM_WAs_o <= fill_addr;
            VRAM_WDs_o <= CLR_DATs_i;
            VRAM_WE_o  <= 1'b1;
            if (fill_done) begin
              state     <= ST_IDLE;
              fill_addr <= '0;
            end else begin
              fill_addr <= fill_addr + C_VRAM_AW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_wr_sched.sv
// Self-checking bench for vram_wr_sched: directed scenarios plus randomized traffic vs a queue model.
module tb_vram_wr_sched;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned BLANK_ONLY = 1;

  logic       CK_i = 1'b0;
  logic       XARST_i = 1'b0;
  logic [9:0] CPU_WAs_i = '0;
  logic [7:0] CPU_WDs_i = '0;
  logic       CPU_WE_i = 1'b0;
  logic       CLR_REQ_i = 1'b0;
  logic [7:0] CLR_DATs_i = '0;
  logic       BLANK_i = 1'b0;
  logic       OVF_CLR_i = 1'b0;
  logic [9:0] VRAM_WAs_o;
  logic [7:0] VRAM_WDs_o;
  logic       VRAM_WE_o;
  logic       BUSY_o;
  logic       OVF_o;
  logic [3:0] FIFO_LVLs_o;

  int checks = 0;
  int failures = 0;

  vram_wr_sched #(.C_FIFO_DEPTH(DEPTH), .C_BLANK_ONLY(BLANK_ONLY)) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .CPU_WAs_i(CPU_WAs_i), .CPU_WDs_i(CPU_WDs_i),
    .CPU_WE_i(CPU_WE_i), .CLR_REQ_i(CLR_REQ_i), .CLR_DATs_i(CLR_DATs_i), .BLANK_i(BLANK_i),
    .OVF_CLR_i(OVF_CLR_i), .VRAM_WAs_o(VRAM_WAs_o), .VRAM_WDs_o(VRAM_WDs_o),
    .VRAM_WE_o(VRAM_WE_o), .BUSY_o(BUSY_o), .OVF_o(OVF_o), .FIFO_LVLs_o(FIFO_LVLs_o)
  );

  always #5 CK_i = ~CK_i;

  // Reference model: the FIFO is a queue, the clear is a pending flag plus a fill counter.
  bit [17:0] q[$];
  bit        m_fill, m_pend, m_ovf, m_we_prev, m_clr_prev;
  int        m_addr;
  logic [9:0] e_wa;
  logic [7:0] e_wd;
  logic       e_we, e_busy;

  always @(posedge CK_i or negedge XARST_i) begin : model
    bit win, pushing, clr_edge, popping, was_empty, old_pend, old_fill, ovf_ev;
    if (!XARST_i) begin
      q.delete();
      m_fill = 0; m_pend = 0; m_ovf = 0; m_addr = 0;
      m_we_prev = 1; m_clr_prev = 1;
      e_we = 0; e_wa = '0; e_wd = '0; e_busy = 0;
    end else begin
      win      = BLANK_i || (BLANK_ONLY == 0);
      pushing  = CPU_WE_i && !m_we_prev;
      clr_edge = CLR_REQ_i && !m_clr_prev;
      old_pend = m_pend;
      old_fill = m_fill;
      popping  = !old_fill && win && (q.size() > 0);
      was_empty = (q.size() == 0);
      ovf_ev   = 0;
      e_we     = 0;
      if (popping) begin
        e_wa = q[0][17:8]; e_wd = q[0][7:0]; e_we = 1;
        void'(q.pop_front());
      end else if (old_fill && win) begin
        e_wa = 10'(m_addr); e_wd = CLR_DATs_i; e_we = 1;
      end
      if (pushing) begin
        if (q.size() < DEPTH) q.push_back({CPU_WAs_i, CPU_WDs_i});
        else ovf_ev = 1;
      end
      if (ovf_ev) m_ovf = 1;
      else if (OVF_CLR_i) m_ovf = 0;
      if (old_fill) begin
        if (win) begin
          if (m_addr == 1023) begin m_fill = 0; m_addr = 0; end
          else m_addr = m_addr + 1;
        end
      end else if (old_pend && was_empty) begin
        m_fill = 1; m_pend = 0;
      end
      if (clr_edge && !old_pend && !old_fill) m_pend = 1;
      e_busy = (q.size() > 0) || m_pend || m_fill;
      m_we_prev  = CPU_WE_i;
      m_clr_prev = CLR_REQ_i;
    end
  end

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge CK_i);
    CPU_WAs_i = a; CPU_WDs_i = d; CPU_WE_i = 1'b1;
    @(negedge CK_i);
    CPU_WE_i = 1'b0;
  endtask

  task automatic test_reset();
    XARST_i = 1'b0;
    repeat (3) @(negedge CK_i);
    checks++;
    if ({VRAM_WE_o, BUSY_o, OVF_o, FIFO_LVLs_o, VRAM_WAs_o, VRAM_WDs_o} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b busy=%b ovf=%b lvl=%0d wa=%h wd=%h want all 0",
               VRAM_WE_o, BUSY_o, OVF_o, FIFO_LVLs_o, VRAM_WAs_o, VRAM_WDs_o);
    end
    XARST_i = 1'b1;
    @(negedge CK_i);
  endtask

  task automatic test_single_write();
    BLANK_i = 1'b1;
    @(negedge CK_i);
    CPU_WAs_i = 10'h155; CPU_WDs_i = 8'hA5; CPU_WE_i = 1'b1;
    @(negedge CK_i);
    checks++;
    if (VRAM_WE_o !== 1'b0) begin
      failures++; $display("FAIL single_early_we got %b want 0", VRAM_WE_o);
    end
    @(negedge CK_i);
    CPU_WE_i = 1'b0;
    checks++;
    if ({VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o} !== {1'b1, 10'h155, 8'hA5}) begin
      failures++;
      $display("FAIL single_pulse got we=%b wa=%h wd=%h want 1 155 a5", VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o);
    end
    @(negedge CK_i);
    checks++;
    if ({VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o} !== {1'b0, 10'h155, 8'hA5}) begin
      failures++;
      $display("FAIL single_hold got we=%b wa=%h wd=%h want 0 155 a5", VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o);
    end
  endtask

  task automatic test_blank_hold();
    logic [9:0] a;
    BLANK_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_write(10'(10'h040 + i), 8'(8'h70 + i));
      checks++;
      if (VRAM_WE_o !== 1'b0) begin
        failures++; $display("FAIL blank_no_write got we=%b want 0 (i=%0d)", VRAM_WE_o, i);
      end
    end
    @(negedge CK_i);
    checks++;
    if (FIFO_LVLs_o !== 4'd3) begin
      failures++; $display("FAIL blank_level got %0d want 3", FIFO_LVLs_o);
    end
    BLANK_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK_i);
      a = 10'(10'h040 + i);
      checks++;
      if ({VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o} !== {1'b1, a, 8'(8'h70 + i)}) begin
        failures++;
        $display("FAIL blank_drain[%0d] got we=%b wa=%h wd=%h want 1 %h %h", i, VRAM_WE_o,
                 VRAM_WAs_o, VRAM_WDs_o, a, 8'(8'h70 + i));
      end
    end
    @(negedge CK_i);
    checks++;
    if ({VRAM_WE_o, FIFO_LVLs_o} !== 5'd0) begin
      failures++; $display("FAIL blank_after got we=%b lvl=%0d want 0 0", VRAM_WE_o, FIFO_LVLs_o);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] ea;
    logic [7:0] ed;
    BLANK_i = 1'b0;
    for (int i = 0; i < 9; i++) cpu_write(10'(10'h100 + i), 8'(8'h10 + i));
    @(negedge CK_i);
    checks++;
    if ({FIFO_LVLs_o, OVF_o} !== {4'd8, 1'b1}) begin
      failures++; $display("FAIL ovf_full got lvl=%0d ovf=%b want 8 1", FIFO_LVLs_o, OVF_o);
    end
    OVF_CLR_i = 1'b1;
    @(negedge CK_i);
    OVF_CLR_i = 1'b0;
    checks++;
    if (OVF_o !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got %b want 0", OVF_o);
    end
    // Push coinciding with a pop on a full FIFO must be kept.
    BLANK_i = 1'b1; CPU_WAs_i = 10'h3FF; CPU_WDs_i = 8'hEE; CPU_WE_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CK_i);
      CPU_WE_i = 1'b0;
      ea = (i < 8) ? 10'(10'h100 + i) : 10'h3FF;
      ed = (i < 8) ? 8'(8'h10 + i) : 8'hEE;
      checks++;
      if ({VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o} !== {1'b1, ea, ed}) begin
        failures++;
        $display("FAIL ovf_drain[%0d] got we=%b wa=%h wd=%h want 1 %h %h", i, VRAM_WE_o,
                 VRAM_WAs_o, VRAM_WDs_o, ea, ed);
      end
    end
    @(negedge CK_i);
    checks++;
    if ({VRAM_WE_o, OVF_o, FIFO_LVLs_o} !== 6'd0) begin
      failures++;
      $display("FAIL ovf_after got we=%b ovf=%b lvl=%0d want 0 0 0", VRAM_WE_o, OVF_o, FIFO_LVLs_o);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    int bad = 0;
    logic [9:0] ea;
    logic [7:0] ed;
    BLANK_i = 1'b0;
    cpu_write(10'h0AA, 8'h11);
    cpu_write(10'h2BB, 8'h22);
    @(negedge CK_i);
    CLR_DATs_i = 8'h20; CLR_REQ_i = 1'b1;
    @(negedge CK_i);
    BLANK_i = 1'b1;
    for (int c = 0; c < 1300 && n < 1026; c++) begin
      @(negedge CK_i);
      if (c == 5) CLR_REQ_i = 1'b0;
      if (VRAM_WE_o === 1'b1) begin
        ea = (n == 0) ? 10'h0AA : (n == 1) ? 10'h2BB : 10'(n - 2);
        ed = (n == 0) ? 8'h11 : (n == 1) ? 8'h22 : 8'h20;
        checks++;
        if ({VRAM_WAs_o, VRAM_WDs_o} !== {ea, ed}) begin
          failures++; bad++;
          if (bad < 5) $display("FAIL fill_write[%0d] got wa=%h wd=%h want %h %h", n,
                                VRAM_WAs_o, VRAM_WDs_o, ea, ed);
        end
        n++;
      end
    end
    checks++;
    if (n != 1026) begin
      failures++; $display("FAIL fill_count got %0d writes want 1026", n);
    end
    @(negedge CK_i);
    checks++;
    if ({VRAM_WE_o, BUSY_o} !== 2'b00) begin
      failures++; $display("FAIL fill_done got we=%b busy=%b want 0 0", VRAM_WE_o, BUSY_o);
    end
  endtask

  task automatic test_fill_pause();
    bit found = 0;
    CLR_DATs_i = 8'h3C; CLR_REQ_i = 1'b1; BLANK_i = 1'b1;
    for (int c = 0; c < 700 && !found; c++) begin
      @(negedge CK_i);
      if (VRAM_WE_o === 1'b1 && VRAM_WAs_o === 10'd499) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL pause_reach got no write at 499 want one");
    end
    BLANK_i = 1'b0; CLR_REQ_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CK_i);
      checks++;
      if (VRAM_WE_o !== 1'b0) begin
        failures++; $display("FAIL pause_hold[%0d] got we=%b want 0", c, VRAM_WE_o);
      end
    end
    BLANK_i = 1'b1;
    @(negedge CK_i);
    checks++;
    if ({VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o} !== {1'b1, 10'd500, 8'h3C}) begin
      failures++;
      $display("FAIL pause_resume got we=%b wa=%0d wd=%h want 1 500 3c", VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o);
    end
    found = 0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(negedge CK_i);
      if (BUSY_o === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL pause_finish got busy=%b want 0 within bound", BUSY_o);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit found = 0;
    CLR_DATs_i = 8'h5A; CLR_REQ_i = 1'b1; BLANK_i = 1'b1;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge CK_i);
      if (VRAM_WE_o === 1'b1 && VRAM_WAs_o === 10'd299) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL rst_reach got no write at 299 want one");
    end
    CPU_WE_i = 1'b1; CPU_WAs_i = 10'h123; CPU_WDs_i = 8'h45;
    XARST_i = 1'b0;
    #1;
    checks++;
    if ({VRAM_WE_o, BUSY_o, OVF_o, FIFO_LVLs_o, VRAM_WAs_o, VRAM_WDs_o} !== 25'd0) begin
      failures++;
      $display("FAIL rst_async got we=%b busy=%b ovf=%b lvl=%0d wa=%h wd=%h want all 0",
               VRAM_WE_o, BUSY_o, OVF_o, FIFO_LVLs_o, VRAM_WAs_o, VRAM_WDs_o);
    end
    repeat (2) @(negedge CK_i);
    XARST_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CK_i);
      if (c == 15) begin CPU_WE_i = 1'b0; CLR_REQ_i = 1'b0; end
      checks++;
      if ({VRAM_WE_o, BUSY_o, FIFO_LVLs_o} !== 6'd0) begin
        failures++;
        $display("FAIL rst_release[%0d] got we=%b busy=%b lvl=%0d want 0 0 0", c, VRAM_WE_o,
                 BUSY_o, FIFO_LVLs_o);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CK_i);
      checks++;
      if ({VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, BUSY_o, OVF_o, FIFO_LVLs_o} !==
          {e_we, e_wa, e_wd, e_busy, m_ovf, 4'(q.size())}) begin
        failures++; bad++;
        if (bad < 8)
          $display("FAIL random[%0d] got we=%b wa=%h wd=%h busy=%b ovf=%b lvl=%0d want %b %h %h %b %b %0d",
                   c, VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, BUSY_o, OVF_o, FIFO_LVLs_o,
                   e_we, e_wa, e_wd, e_busy, m_ovf, q.size());
      end
      CPU_WE_i   = 1'($urandom_range(0, 1));
      CPU_WAs_i  = 10'($urandom);
      CPU_WDs_i  = 8'($urandom);
      BLANK_i    = ($urandom_range(0, 3) != 0);
      OVF_CLR_i  = ($urandom_range(0, 15) == 0);
      CLR_REQ_i  = ($urandom_range(0, 599) == 0);
      CLR_DATs_i = 8'($urandom);
    end
    CPU_WE_i = 1'b0; OVF_CLR_i = 1'b0; CLR_REQ_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_blank_hold();
    test_overflow();
    test_fill();
    test_fill_pause();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
